// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore decode of the state register, plus a funct-decoded ALU control.
// Optional LUI support is compiled in with `define MC_LUI_EN; without it the LUI opcode traps.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
`ifdef MC_LUI_EN
    S_LUI      = 4'd11,
`endif
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MC_LUI_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_dec;
  logic       alu_op_ok;

  // Only EXECR may turn funct3=000 into a subtract; addi never does.
  always_comb begin
    alu_dec   = ALU_ADD;
    alu_op_ok = 1'b1;
    case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
`ifdef MC_LUI_EN
          OP_LUI:            state_d = S_LUI;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = alu_op_ok ? S_ALUWB : S_TRAP;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = (funct3 == 3'b000) ? S_FETCH : S_TRAP;
`ifdef MC_LUI_EN
      S_LUI:      state_d = S_ALUWB;
`endif
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Everything is forced low during reset so no strobe (FETCH's mem_req included) leaks out.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 3'b000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = alu_dec;
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_dec;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          imm_src   = 3'b011;
          pc_write  = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = zero;
        end
`ifdef MC_LUI_EN
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          imm_src   = 3'b100;
        end
`endif
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q & ~reset;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a vector table of whole instructions plus hand-written
// sequences for memory wait states, traps, async reset and the MC_LUI_EN option.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int          len;
    logic [23:0] seq;   // nibble c = expected state code in cycle c
    logic [2:0]  alu;   // expectations for cycle 2 (first state after DECODE)
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  imm;
    logic        pcw;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string nm, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                              int len, logic [23:0] seq, logic [2:0] alu, logic [1:0] sa,
                              logic [1:0] sb, logic [2:0] imm, logic pcw);
    vec_t r;
    r.name = nm; r.op = op; r.f3 = f3; r.f7 = f7; r.z = z; r.len = len; r.seq = seq;
    r.alu = alu; r.sa = sa; r.sb = sb; r.imm = imm; r.pcw = pcw;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.state", state_o, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.ir_write", ir_write, 0);
    chk("rst.pc_write", pc_write, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.reg_write", reg_write, 0);
    chk("rst.result_src", result_src, 0);
    chk("rst.alu_src_b", alu_src_b, 0);
    chk("rst.illegal", illegal, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst.state", state_o, 0);
    chk("post_rst.illegal", illegal, 0);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    logic [3:0] s;
    vecs[0]  = mk("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4, 24'h007610, 3'b000, 2'b10, 2'b00, 3'b000, 1'b0);
    vecs[1]  = mk("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, 24'h007610, 3'b001, 2'b10, 2'b00, 3'b000, 1'b0);
    vecs[2]  = mk("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4, 24'h007610, 3'b101, 2'b10, 2'b00, 3'b000, 1'b0);
    vecs[3]  = mk("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4, 24'h007610, 3'b011, 2'b10, 2'b00, 3'b000, 1'b0);
    vecs[4]  = mk("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 4, 24'h007610, 3'b010, 2'b10, 2'b00, 3'b000, 1'b0);
    vecs[5]  = mk("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, 24'h007810, 3'b000, 2'b10, 2'b01, 3'b000, 1'b0);
    vecs[6]  = mk("ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 4, 24'h007810, 3'b011, 2'b10, 2'b01, 3'b000, 1'b0);
    vecs[7]  = mk("slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 4, 24'h007810, 3'b101, 2'b10, 2'b01, 3'b000, 1'b0);
    vecs[8]  = mk("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5, 24'h043210, 3'b000, 2'b10, 2'b01, 3'b000, 1'b0);
    vecs[9]  = mk("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4, 24'h005210, 3'b000, 2'b10, 2'b01, 3'b001, 1'b0);
    vecs[10] = mk("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4, 24'h007910, 3'b000, 2'b01, 2'b10, 3'b011, 1'b1);
    vecs[11] = mk("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 24'h000A10, 3'b001, 2'b10, 2'b00, 3'b000, 1'b1);
    vecs[12] = mk("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 24'h000A10, 3'b001, 2'b10, 2'b00, 3'b000, 1'b0);

    do_reset();

    // FETCH wait: mem_ready low holds FETCH with no write enables.
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fwait%0d.state", i), state_o, 0);
      chk($sformatf("fwait%0d.mem_req", i), mem_req, 1);
      chk($sformatf("fwait%0d.ir_write", i), ir_write, 0);
      chk($sformatf("fwait%0d.pc_write", i), pc_write, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("fwait.ir_write", ir_write, 1);
    chk("fwait.pc_write", pc_write, 1);
    tick();
    chk("fwait.decode", state_o, 1);
    tick();
    chk("fwait.execr", state_o, 6);
    tick();
    chk("fwait.aluwb", state_o, 7);
    tick();

    for (int v = 0; v < 13; v++) begin
      set_instr(vecs[v].op, vecs[v].f3, vecs[v].f7);
      zero = vecs[v].z;
      mem_ready = 1'b1;
      #1;
      for (int c = 0; c < vecs[v].len; c++) begin
        s = vecs[v].seq[4*c +: 4];
        chk($sformatf("%s.c%0d.state", vecs[v].name, c), state_o, s);
        chk($sformatf("%s.c%0d.mem_req", vecs[v].name, c), mem_req, (s == 0 || s == 3 || s == 5));
        chk($sformatf("%s.c%0d.mem_write", vecs[v].name, c), mem_write, (s == 5));
        chk($sformatf("%s.c%0d.adr_src", vecs[v].name, c), adr_src, (s == 3 || s == 5));
        chk($sformatf("%s.c%0d.reg_write", vecs[v].name, c), reg_write, (s == 4 || s == 7));
        chk($sformatf("%s.c%0d.ir_write", vecs[v].name, c), ir_write, (s == 0));
        chk($sformatf("%s.c%0d.result_src", vecs[v].name, c), result_src,
            (s == 0) ? 8'd2 : (s == 4) ? 8'd1 : 8'd0);
        if (c == 0) begin
          chk($sformatf("%s.fetch.pc_write", vecs[v].name), pc_write, 1);
          chk($sformatf("%s.fetch.src_b", vecs[v].name), alu_src_b, 2);
        end
        if (c == 1) begin
          chk($sformatf("%s.decode.src_a", vecs[v].name), alu_src_a, 1);
          chk($sformatf("%s.decode.src_b", vecs[v].name), alu_src_b, 1);
          chk($sformatf("%s.decode.imm", vecs[v].name), imm_src, 2);
        end
        if (c == 2) begin
          chk($sformatf("%s.key.alu", vecs[v].name), alu_control, vecs[v].alu);
          chk($sformatf("%s.key.src_a", vecs[v].name), alu_src_a, vecs[v].sa);
          chk($sformatf("%s.key.src_b", vecs[v].name), alu_src_b, vecs[v].sb);
          chk($sformatf("%s.key.imm", vecs[v].name), imm_src, vecs[v].imm);
          chk($sformatf("%s.key.pc_write", vecs[v].name), pc_write, vecs[v].pcw);
        end
        tick();
      end
    end
    chk("vec_end.state", state_o, 0);

    // Load with three wait cycles in MEMREAD.
    set_instr(7'b0000011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk("lwait.decode", state_o, 1);
    tick();
    chk("lwait.memadr", state_o, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk($sformatf("lwait%0d.state", i), state_o, 3);
      chk($sformatf("lwait%0d.mem_req", i), mem_req, 1);
      chk($sformatf("lwait%0d.adr_src", i), adr_src, 1);
      chk($sformatf("lwait%0d.reg_write", i), reg_write, 0);
      tick();
    end
    chk("lwait.memwb", state_o, 4);
    chk("lwait.memwb.reg_write", reg_write, 1);
    chk("lwait.memwb.result_src", result_src, 1);
    tick();
    chk("lwait.fetch", state_o, 0);

    // Store waiting in MEMWRITE, then asynchronous reset mid-wait.
    set_instr(7'b0100011, 3'b010, 1'b0);
    tick();
    tick();
    chk("swrst.memadr.imm", imm_src, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("swrst.memwrite", state_o, 5);
    chk("swrst.mem_write", mem_write, 1);
    tick();
    chk("swrst.held", state_o, 5);
    reset = 1'b1;
    #1;
    chk("swrst.async.mem_write", mem_write, 0);
    chk("swrst.async.mem_req", mem_req, 0);
    chk("swrst.async.state", state_o, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("swrst.after.state", state_o, 0);
    chk("swrst.after.ir_write", ir_write, 1);

    // Illegal opcode: sticky trap until reset.
    set_instr(7'b0000000, 3'b000, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("trap%0d.state", i), state_o, 12);
      chk($sformatf("trap%0d.illegal", i), illegal, 1);
      chk($sformatf("trap%0d.mem_req", i), mem_req, 0);
      chk($sformatf("trap%0d.pc_write", i), pc_write, 0);
      tick();
    end
    do_reset();

    // Unsupported funct3 in EXECR traps instead of writing back.
    set_instr(7'b0110011, 3'b001, 1'b0);
    tick();
    tick();
    chk("r_bad.execr", state_o, 6);
    tick();
    chk("r_bad.trap", state_o, 12);
    chk("r_bad.illegal", illegal, 1);
    do_reset();

    // BEQ with funct3 != 000 traps.
    set_instr(7'b1100011, 3'b001, 1'b0);
    tick();
    tick();
    chk("beq_bad.beq", state_o, 10);
    tick();
    chk("beq_bad.trap", state_o, 12);
    chk("beq_bad.illegal", illegal, 1);
    do_reset();

    // lui x1,0x12345 (0x123450B7)
    set_instr(7'b0110111, 3'b000, 1'b0);
    tick();
    chk("lui.decode", state_o, 1);
    tick();
`ifdef MC_LUI_EN
    chk("lui.state", state_o, 11);
    chk("lui.imm", imm_src, 4);
    chk("lui.src_a", alu_src_a, 3);
    chk("lui.src_b", alu_src_b, 1);
    chk("lui.alu", alu_control, 0);
    tick();
    chk("lui.aluwb", state_o, 7);
    chk("lui.reg_write", reg_write, 1);
    tick();
    chk("lui.fetch", state_o, 0);
    chk("lui.illegal", illegal, 0);
`else
    chk("lui.trap", state_o, 12);
    chk("lui.illegal", illegal, 1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
